// File: rtl/alu_unit.sv
// Registered 4-function ALU: subtract, signed compare, logical shift, bit set/clear.
// One-cycle latency. Parity and one-hot flags are decoded from the registered result.
module alu_unit #(
  parameter int BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  input  logic [1:0]      i_op,
  output logic [BITS-1:0] o_out,
  output logic            o_ovf,
  output logic            o_ERR,
  output logic            o_even,
  output logic            o_single
);

  localparam int IDX_W = $clog2(BITS);

  typedef enum logic [1:0] {
    OP_SUB    = 2'b00,
    OP_CMP    = 2'b01,
    OP_SHIFT  = 2'b10,
    OP_BITCHG = 2'b11
  } op_e;

  // BITS always fits in BITS-1 bits for BITS >= 4, so this compare is exact.
  localparam logic [BITS-2:0] SHAMT_LIMIT = BITS[BITS-2:0];

  logic [BITS-1:0] out_d, out_q;
  logic            ovf_d, ovf_q;
  logic            err_d, err_q;

  logic [BITS-1:0]   diff;
  logic              shift_right;
  logic [BITS-2:0]   shamt;
  logic [2*BITS-1:0] shl_wide;
  logic [2*BITS-1:0] shr_wide;
  logic [IDX_W-1:0]  bit_idx;
  logic              bit_val;
  logic              idx_bad;

  always_comb begin
    diff        = i_a - i_b;
    shift_right = i_b[BITS-1];
    shamt       = i_b[BITS-2:0];
    // Double-width shifts keep the bits pushed out, which feed the data-lost flag.
    shl_wide    = {{BITS{1'b0}}, i_a} << shamt;
    shr_wide    = {i_a, {BITS{1'b0}}} >> shamt;
    bit_idx     = i_b[IDX_W-1:0];
    bit_val     = i_b[BITS-1];
    idx_bad     = |i_b[BITS-2:IDX_W];
  end

  // NOTE: every output of this block gets a default first so no latch is inferred
  // on paths that do not assign it.
  always_comb begin
    out_d = '0;
    ovf_d = 1'b0;
    err_d = 1'b0;
    unique case (op_e'(i_op))
      OP_SUB: begin
        out_d = diff;
        ovf_d = (i_a[BITS-1] != i_b[BITS-1]) && (diff[BITS-1] != i_a[BITS-1]);
      end
      OP_CMP: begin
        out_d[0] = $signed(i_a) > $signed(i_b);
      end
      OP_SHIFT: begin
        if (shamt >= SHAMT_LIMIT) begin
          err_d = 1'b1;
        end else if (shift_right) begin
          out_d = shr_wide[2*BITS-1:BITS];
          ovf_d = |shr_wide[BITS-1:0];
        end else begin
          out_d = shl_wide[BITS-1:0];
          ovf_d = |shl_wide[2*BITS-1:BITS];
        end
      end
      OP_BITCHG: begin
        if (idx_bad) begin
          err_d = 1'b1;
        end else begin
          out_d          = i_a;
          out_d[bit_idx] = bit_val;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign o_out    = out_q;
  assign o_ovf    = ovf_q;
  assign o_ERR    = err_q;
  assign o_even   = ~^out_q;
  assign o_single = (out_q != '0) && ((out_q & (out_q - 1'b1)) == '0);

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: table of hand-computed results applied
// back-to-back, plus reset-at-start and mid-stream reset sequences.
module tb_alu_unit;

  localparam int BITS = 8;

  logic            i_clk;
  logic            i_rst;
  logic [BITS-1:0] i_a;
  logic [BITS-1:0] i_b;
  logic [1:0]      i_op;
  logic [BITS-1:0] o_out;
  logic            o_ovf;
  logic            o_ERR;
  logic            o_even;
  logic            o_single;

  alu_unit #(.BITS(BITS)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_op     (i_op),
    .o_out    (o_out),
    .o_ovf    (o_ovf),
    .o_ERR    (o_ERR),
    .o_even   (o_even),
    .o_single (o_single)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]      op;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] out;
    logic            ovf;
    logic            err;
    logic            even;
    logic            single;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] out, input logic ovf, input logic err,
                              input logic even, input logic single);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.out = out;
    v.ovf = ovf; v.err = err; v.even = even; v.single = single;
    return v;
  endfunction

  // Compared tuple: {out, ovf, err, even, single}
  task automatic check(input string name, input logic [BITS+3:0] got, input logic [BITS+3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got out=%h ovf=%b err=%b even=%b single=%b, want out=%h ovf=%b err=%b even=%b single=%b",
               name, got[BITS+3:4], got[3], got[2], got[1], got[0],
               exp[BITS+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [BITS+3:0] dut_tuple();
    return {o_out, o_ovf, o_ERR, o_even, o_single};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    @(negedge i_clk);
    i_op = op; i_a = a; i_b = b;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    drive(v.op, v.a, v.b);
    @(posedge i_clk);
    #1;
    check(name, dut_tuple(), {v.out, v.ovf, v.err, v.even, v.single});
  endtask

  localparam logic [BITS+3:0] RESET_TUPLE = {{BITS{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    //                op     a      b      out    ovf   err   even  single
    // SUB
    vecs.push_back(mk(2'b00, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(2'b00, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2'b00, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2'b00, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1));
    // CMP
    vecs.push_back(mk(2'b01, 8'h03, 8'h81, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(2'b01, 8'h81, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2'b01, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2'b01, 8'h7F, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1));
    // SHIFT
    vecs.push_back(mk(2'b10, 8'h82, 8'h02, 8'h08, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(2'b10, 8'h03, 8'h81, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(2'b10, 8'h43, 8'h04, 8'h30, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2'b10, 8'hC0, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(2'b10, 8'h03, 8'h03, 8'h18, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2'b10, 8'h03, 8'h08, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(2'b10, 8'h5A, 8'h80, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2'b10, 8'h80, 8'h87, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(2'b10, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(2'b10, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1));
    // BITCHG
    vecs.push_back(mk(2'b11, 8'hAA, 8'h81, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(2'b11, 8'hAA, 8'h01, 8'hA8, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2'b11, 8'hAA, 8'h07, 8'h2A, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2'b11, 8'hAA, 8'h03, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2'b11, 8'hFF, 8'h01, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(2'b11, 8'hFF, 8'h11, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(2'b11, 8'h00, 8'h84, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1));

    i_rst = 1'b1;
    i_op  = 2'b00;
    i_a   = '0;
    i_b   = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_initial", dut_tuple(), RESET_TUPLE);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Table applied back-to-back: a new op every cycle, checked one edge later.
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Mid-stream reset: a nonzero result is in the register, then reset is held
    // for two edges while an overflowing SUB is presented; reset must win.
    run_vec(mk(2'b00, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0), "pre_reset_sub");
    drive(2'b00, 8'h80, 8'h01);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check("mid_reset_edge1", dut_tuple(), RESET_TUPLE);
    @(posedge i_clk);
    #1;
    check("mid_reset_edge2", dut_tuple(), RESET_TUPLE);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    check("post_reset_sub", dut_tuple(), {8'h7F, 1'b1, 1'b0, 1'b0, 1'b0});

    // Result must change exactly one edge after the op changes: sample just
    // before the edge (old value) and just after (new value).
    drive(2'b10, 8'h03, 8'h08);
    @(posedge i_clk);
    #1;
    check("b2b_shift_err", dut_tuple(), {8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
    drive(2'b01, 8'h03, 8'h81);
    #4;
    check("b2b_hold_before_edge", dut_tuple(), {8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
    @(posedge i_clk);
    #1;
    check("b2b_cmp_after_edge", dut_tuple(), {8'h01, 1'b0, 1'b0, 1'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
